// File: rtl/pktbuf_rd_arb_pkg.sv
// Shared types and constants for the packet-buffer read arbiter.
package pktbuf_rd_arb_pkg;

  localparam int PKTBUF_AWIDTH = 10;
  localparam int FLIT_WIDTH    = 32;

  typedef logic [FLIT_WIDTH-1:0] flit_t;

  // Grant ownership: free arbitration, or port held by one requester for a burst.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Identifies which requester issued an outstanding read.
  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/pktbuf_rd_arb_if.sv
// Bundle of the two requester ports, the packet-buffer read port and status.
interface pktbuf_rd_arb_if #(
  parameter int AWIDTH = pktbuf_rd_arb_pkg::PKTBUF_AWIDTH
);
  import pktbuf_rd_arb_pkg::*;

  logic              req0_read;
  logic [AWIDTH-1:0] req0_address;
  logic              req0_lock;
  logic              req0_ready;
  logic              req0_readvalid;
  flit_t             req0_readdata;

  logic              req1_read;
  logic [AWIDTH-1:0] req1_address;
  logic              req1_lock;
  logic              req1_ready;
  logic              req1_readvalid;
  flit_t             req1_readdata;

  logic [AWIDTH-1:0] pkt_buffer_readaddress;
  logic              pkt_buffer_read;
  logic              pkt_buffer_readvalid;
  flit_t             pkt_buffer_readdata;

  logic              err_orphan;
  logic [31:0]       stats_grant0;
  logic [31:0]       stats_grant1;

  // Arbiter side.
  modport slave (
    input  req0_read, req0_address, req0_lock,
    output req0_ready, req0_readvalid, req0_readdata,
    input  req1_read, req1_address, req1_lock,
    output req1_ready, req1_readvalid, req1_readdata,
    output pkt_buffer_readaddress, pkt_buffer_read,
    input  pkt_buffer_readvalid, pkt_buffer_readdata,
    output err_orphan, stats_grant0, stats_grant1
  );

  // Requester / memory / monitor side.
  modport master (
    output req0_read, req0_address, req0_lock,
    input  req0_ready, req0_readvalid, req0_readdata,
    output req1_read, req1_address, req1_lock,
    input  req1_ready, req1_readvalid, req1_readdata,
    input  pkt_buffer_readaddress, pkt_buffer_read,
    output pkt_buffer_readvalid, pkt_buffer_readdata,
    input  err_orphan, stats_grant0, stats_grant1
  );

endinterface

// File: rtl/pktbuf_rd_arb_rd_tag_fifo.sv
// rd_tag_fifo: in-order FIFO of 1-bit requester tags for split-transaction
// read ports. Head is visible combinationally so returns route with no delay.
// Pushes while full and pops while empty are ignored.
module pktbuf_rd_arb_rd_tag_fifo
  import pktbuf_rd_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     push,
  input  req_id_t                  push_id,
  input  logic                     pop,
  output req_id_t                  head_id,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  req_id_t         tags_reg [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW:0]     count_reg;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head_id = tags_reg[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Tag storage; contents are don't-care until written, so no reset.
  always_ff @(posedge Clk) begin
    if (do_push) tags_reg[wr_ptr_reg] <= push_id;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pktbuf_rd_arb.sv
// Two-way arbiter for the packet-buffer read port: req0 (data mover) and
// req1 (replay/debug). Supports locked bursts, registered issue, in-order
// tag tracking of outstanding reads and per-requester return routing.
module pktbuf_rd_arb
  import pktbuf_rd_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int AWIDTH          = PKTBUF_AWIDTH
) (
  input logic            Clk,
  input logic            Rst_n,
  pktbuf_rd_arb_if.slave bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_OWN0 = OWN0;
  localparam logic [1:0] ST_OWN1 = OWN1;

  logic [1:0]        state_reg, state_next;
  logic              rr_reg, rr_next;
  logic              rd_issue_reg;
  logic [AWIDTH-1:0] rd_addr_reg;
  logic              err_orphan_reg;
  logic [31:0]       grant0_reg, grant1_reg;

  logic              gnt0, gnt1;
  logic              space;
  logic              acc0, acc1;
  logic [CW-1:0]     inflight;
  req_id_t           head_id;
  logic              tag_empty;
  logic              unused_tag_full;

  // Readiness is judged on the registered count, so a pop this cycle frees
  // its slot only next cycle.
  assign space = (inflight < CW'(MAX_OUTSTANDING));

  // Grant selection: an owner excludes the other side; otherwise a lone
  // requester wins and a tie goes to the round-robin pointer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_reg)
      ST_OWN0: gnt0 = bus.req0_read;
      ST_OWN1: gnt1 = bus.req1_read;
      default: begin
        gnt0 = bus.req0_read && (!rr_reg || !bus.req1_read);
        gnt1 = bus.req1_read && ( rr_reg || !bus.req0_read);
      end
    endcase
  end

  // Readies are forced low while reset is held.
  assign acc0 = Rst_n && gnt0 && space;
  assign acc1 = Rst_n && gnt1 && space;
  assign bus.req0_ready = acc0;
  assign bus.req1_ready = acc1;

  // Ownership and round-robin update.
  always_comb begin
    state_next = state_reg;
    rr_next    = rr_reg;
    case (state_reg)
      ST_OWN0: begin
        if (acc0 && !bus.req0_lock) begin
          state_next = ST_IDLE;
          rr_next    = 1'b1;
        end else if (!bus.req0_read && !bus.req0_lock) begin
          state_next = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (acc1 && !bus.req1_lock) begin
          state_next = ST_IDLE;
          rr_next    = 1'b0;
        end else if (!bus.req1_read && !bus.req1_lock) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        if (acc0) begin
          if (bus.req0_lock) state_next = ST_OWN0;
          else               rr_next    = 1'b1;
        end else if (acc1) begin
          if (bus.req1_lock) state_next = ST_OWN1;
          else               rr_next    = 1'b0;
        end
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= ST_IDLE;
      rr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
    end
  end

  // One-cycle registered issue to the buffer; address holds when idle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_issue_reg <= 1'b0;
      rd_addr_reg  <= '0;
    end else begin
      rd_issue_reg <= acc0 || acc1;
      if (acc0)      rd_addr_reg <= bus.req0_address;
      else if (acc1) rd_addr_reg <= bus.req1_address;
    end
  end

  // Sticky orphan flag and wrapping grant counters.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      err_orphan_reg <= 1'b0;
      grant0_reg     <= '0;
      grant1_reg     <= '0;
    end else begin
      if (bus.pkt_buffer_readvalid && tag_empty) err_orphan_reg <= 1'b1;
      if (acc0) grant0_reg <= grant0_reg + 32'd1;
      if (acc1) grant1_reg <= grant1_reg + 32'd1;
    end
  end

  pktbuf_rd_arb_rd_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .push    (acc0 || acc1),
    .push_id (acc1 ? REQ1 : REQ0),
    .pop     (bus.pkt_buffer_readvalid),
    .head_id (head_id),
    .count   (inflight),
    .full    (unused_tag_full),
    .empty   (tag_empty)
  );

  assign bus.pkt_buffer_read        = rd_issue_reg;
  assign bus.pkt_buffer_readaddress = rd_addr_reg;

  // Returns go to the head tag's owner; an empty queue means an orphan.
  assign bus.req0_readvalid = bus.pkt_buffer_readvalid && !tag_empty && (head_id == REQ0);
  assign bus.req1_readvalid = bus.pkt_buffer_readvalid && !tag_empty && (head_id == REQ1);
  assign bus.req0_readdata  = bus.pkt_buffer_readdata;
  assign bus.req1_readdata  = bus.pkt_buffer_readdata;

  assign bus.err_orphan   = err_orphan_reg;
  assign bus.stats_grant0 = grant0_reg;
  assign bus.stats_grant1 = grant1_reg;

endmodule
